vga_pattern_gen: RTL and testbench

Parametrised VGA/LCD timing generator with a runtime-selectable test-pattern source. It drives a `video_if` master port (CLK, HS, VS, BLANK, RGB) in the pixel clock domain. It generalises the fixed 800x480 grid generator: full timing parametrisation, configurable sync polarity, five pattern modes, enable control, and frame bookkeeping. It sits in front of the display PHY and serves as the bring-up and fallback source when no framebuffer stream is present.

---
 rtl/vga_pattern_gen_if.sv | 11 +
 rtl/vga_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Video output bundle driven by the pattern generator toward the display PHY.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA/LCD timing generator with a frame-latched, runtime-selectable
// test-pattern source. Every output is registered one cycle behind the counters.
module vga_pattern_gen #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int HFP        = 40,
  parameter int HPULSE     = 48,
  parameter int HBP        = 40,
  parameter int VFP        = 13,
  parameter int VPULSE     = 3,
  parameter int VBP        = 29,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int GRID_STEP  = 16,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        en,
  input  logic [2:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic [15:0] frame_cnt,
  output logic        frame_start,
  video_if.master     video_ifm
);
  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int GW     = $clog2(GRID_STEP);
  localparam int BAR_W  = HDISP / 8;
  localparam int BW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_end, v_end, h_sync, v_sync, h_act, v_act, act, fs;
  logic [2:0]    mode_q, mode_eff;
  logic [23:0]   rgb_q, rgb_eff;

  assign h_end  = (h_cnt == HW'(HTOTAL - 1));
  assign v_end  = (v_cnt == VW'(VTOTAL - 1));
  assign h_sync = (h_cnt >= HW'(HFP)) && (h_cnt < HW'(HFP + HPULSE));
  assign v_sync = (v_cnt >= VW'(VFP)) && (v_cnt < VW'(VFP + VPULSE));
  assign h_act  = (h_cnt >= HW'(HSTART));
  assign v_act  = (v_cnt >= VW'(VSTART));
  assign act    = h_act && v_act;
  assign fs     = en && (h_cnt == '0) && (v_cnt == '0);

  // Disabled means parked at frame start, so re-enable always begins a clean frame.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      if (h_end && v_end) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      mode_q <= '0;
      rgb_q  <= '0;
    end else if (fs) begin
      mode_q <= mode;
      rgb_q  <= solid_rgb;
    end
  end

  // Bypass the latch on the frame-start cycle so that cycle already uses the new mode.
  assign mode_eff = fs ? mode : mode_q;
  assign rgb_eff  = fs ? solid_rgb : rgb_q;

  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [15:0]   x_ext, y_ext;
  assign x     = h_cnt - HW'(HSTART);
  assign y     = v_cnt - VW'(VSTART);
  assign x_ext = 16'(x);
  assign y_ext = 16'(y);

  // Bar index tracks x for the current h_cnt; it restarts during every blanking stretch.
  logic [BW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!h_act) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BW'(BAR_W - 1)) begin
      bar_pos <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  logic [23:0] bar_rgb, pix;
  always_comb begin
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    pix = 24'h000000;
    case (mode_eff)
      3'd0: pix = ((x_ext[GW-1:0] == '0) || (y_ext[GW-1:0] == '0)) ? 24'hFFFFFF : 24'h000000;
      3'd1: pix = bar_rgb;
      3'd2: pix = (x_ext[CHECK_LOG2] ^ y_ext[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      3'd3: pix = {3{x_ext[7:0]}};
      3'd4: pix = rgb_eff;
      default: pix = 24'h000000;
    endcase
  end

  logic        hs_r, vs_r, blank_r;
  logic [23:0] rgb_r;
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst || !en) begin
      hs_r        <= ~HS_POL;
      vs_r        <= ~VS_POL;
      blank_r     <= 1'b0;
      rgb_r       <= '0;
      frame_start <= 1'b0;
    end else begin
      hs_r        <= h_sync ? HS_POL : ~HS_POL;
      vs_r        <= v_sync ? VS_POL : ~VS_POL;
      blank_r     <= act;
      rgb_r       <= act ? pix : 24'h000000;
      frame_start <= fs;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_r;
  assign video_ifm.VS    = vs_r;
  assign video_ifm.BLANK = blank_r;
  assign video_ifm.RGB   = rgb_r;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: small-frame instance for timing/patterns/enable,
// plus a 640-wide positive-polarity instance for sync polarity and line period.
module tb_vga_pattern_gen;
  localparam int HT = 80, VT = 23, HS0 = 16, VS0 = 7, FRAME = HT * VT;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [23:0] solid = 24'h0;
  logic [15:0] fcnt, fcnt2, fc0;
  logic        fs, fs2;
  int          n_vec = 0, n_err = 0;
  int          hs_low, first_hs, vs_low, blk, rgb_bad, fs_extra, bad, hi, per;

  video_if vif ();
  video_if vif2 ();

  vga_pattern_gen #(.HDISP(64), .VDISP(16), .HFP(4), .HPULSE(6), .HBP(6),
                    .VFP(2), .VPULSE(2), .VBP(3), .GRID_STEP(16), .CHECK_LOG2(3))
  dut (.pixel_clk(clk), .pixel_rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
       .frame_cnt(fcnt), .frame_start(fs), .video_ifm(vif));

  vga_pattern_gen #(.HDISP(640), .VDISP(480), .HS_POL(1'b1), .VS_POL(1'b1))
  dut2 (.pixel_clk(clk), .pixel_rst(rst), .en(1'b1), .mode(3'd0), .solid_rgb(24'h0),
        .frame_cnt(fcnt2), .frame_start(fs2), .video_ifm(vif2));

  always #5 clk = ~clk;

  typedef struct {
    int          grp;
    logic [2:0]  mode;
    logic [23:0] solid;
    int          pos;
    logic        blank;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  function automatic void raw(int g, logic [2:0] m, logic [23:0] s, int h, int v,
                              logic b, logic [23:0] c);
    vec_t e;
    e.grp = g; e.mode = m; e.solid = s; e.pos = v * HT + h; e.blank = b; e.rgb = c;
    vecs.push_back(e);
  endfunction

  function automatic void px(int g, logic [2:0] m, logic [23:0] s, int x, int y, logic [23:0] c);
    raw(g, m, s, HS0 + x, VS0 + y, 1'b1, c);
  endfunction

  function automatic void sb_px(int x, int y, logic [23:0] c);
    vec_t e;
    e.grp = -1; e.mode = 3'd0; e.solid = 24'h0;
    e.pos = (VS0 + y) * HT + HS0 + x; e.blank = 1'b1; e.rgb = c;
    sbq.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (fs !== 1'b1 && n < 2 * FRAME);
    if (fs !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL %s: no frame_start within %0d cycles", tag, n);
    end
  endtask

  // Called on the frame_start sample (cycle 0); compares queued pixels as they appear.
  task automatic drain(input int chg_cyc, input logic [2:0] cm, input logic [23:0] cs);
    int   cyc = 0;
    vec_t e;
    while (sbq.size() > 0 && cyc < FRAME) begin
      if (sbq[0].pos == cyc) begin
        e = sbq.pop_front();
        n_vec++;
        if ({vif.BLANK, vif.RGB} !== {e.blank, e.rgb}) begin
          n_err++;
          $display("FAIL pixel h=%0d v=%0d: got blank=%b rgb=%h expected blank=%b rgb=%h",
                   e.pos % HT, e.pos / HT, vif.BLANK, vif.RGB, e.blank, e.rgb);
        end
      end else if (sbq[0].pos < cyc) begin
        e = sbq.pop_front();
        n_vec++; n_err++;
        $display("FAIL pixel_order pos=%0d: passed at cycle %0d", e.pos, cyc);
      end else begin
        @(negedge clk);
        cyc++;
        if (cyc == chg_cyc) begin mode = cm; solid = cs; end
      end
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++; n_err++;
      $display("FAIL pixel_timeout pos=%0d: never reached", e.pos);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // group 0: grid
    raw(0, 3'd0, 24'h0, 20, 3, 1'b0, 24'h0);
    px (0, 3'd0, 24'h0, 3, 0, 24'hFFFFFF);
    px (0, 3'd0, 24'h0, 5, 0, 24'hFFFFFF);
    raw(0, 3'd0, 24'h0, 2, VS0 + 1, 1'b0, 24'h0);
    raw(0, 3'd0, 24'h0, 6, VS0 + 1, 1'b0, 24'h0);
    px (0, 3'd0, 24'h0, 0, 1, 24'hFFFFFF);
    px (0, 3'd0, 24'h0, 1, 1, 24'h000000);
    px (0, 3'd0, 24'h0, 15, 1, 24'h000000);
    px (0, 3'd0, 24'h0, 16, 1, 24'hFFFFFF);
    px (0, 3'd0, 24'h0, 7, 15, 24'h000000);
    // group 1: colour bars, 8 pixels wide
    px (1, 3'd1, 24'h0, 0, 0, 24'hFFFFFF);
    px (1, 3'd1, 24'h0, 7, 0, 24'hFFFFFF);
    px (1, 3'd1, 24'h0, 8, 0, 24'hFFFF00);
    px (1, 3'd1, 24'h0, 16, 0, 24'h00FFFF);
    px (1, 3'd1, 24'h0, 24, 0, 24'h00FF00);
    px (1, 3'd1, 24'h0, 32, 0, 24'hFF00FF);
    px (1, 3'd1, 24'h0, 40, 0, 24'hFF0000);
    px (1, 3'd1, 24'h0, 50, 0, 24'h0000FF);
    px (1, 3'd1, 24'h0, 63, 0, 24'h000000);
    px (1, 3'd1, 24'h0, 8, 5, 24'hFFFF00);
    // group 2: checker, 8-pixel squares
    px (2, 3'd2, 24'h0, 0, 0, 24'hFFFFFF);
    px (2, 3'd2, 24'h0, 8, 0, 24'h000000);
    px (2, 3'd2, 24'h0, 8, 8, 24'hFFFFFF);
    px (2, 3'd2, 24'h0, 3, 9, 24'h000000);
    // group 3: ramp
    px (3, 3'd3, 24'h0, 0, 0, 24'h000000);
    px (3, 3'd3, 24'h0, 44, 2, 24'h2C2C2C);
    raw(3, 3'd3, 24'h0, 2, 10, 1'b0, 24'h0);
    px (3, 3'd3, 24'h0, 63, 14, 24'h3F3F3F);
    // group 4: solid
    px (4, 3'd4, 24'h123456, 0, 0, 24'h123456);
    raw(4, 3'd4, 24'h123456, 10, 12, 1'b0, 24'h0);
    px (4, 3'd4, 24'h123456, 31, 7, 24'h123456);
    px (4, 3'd4, 24'h123456, 63, 14, 24'h123456);
    // groups 5,6: reserved modes are black
    px (5, 3'd5, 24'h123456, 10, 3, 24'h000000);
    px (5, 3'd5, 24'h123456, 40, 6, 24'h000000);
    px (6, 3'd7, 24'h123456, 1, 1, 24'h000000);

    repeat (3) @(negedge clk);
    chk("reset_idle", 64'({vif.HS, vif.VS, vif.BLANK, vif.RGB, fs, fcnt}),
        64'({1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 16'h0}));
    chk("reset_idle_pol1", 64'({vif2.HS, vif2.VS, vif2.BLANK}), 64'({1'b0, 1'b0, 1'b0}));
    rst = 1'b0;

    wait_fs("first_frame");
    chk("fcnt_first", 64'(fcnt), 64'(0));
    hs_low = 0; first_hs = -1; vs_low = 0; blk = 0; rgb_bad = 0; fs_extra = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (!vif.HS) begin hs_low++; if (first_hs < 0) first_hs = c; end
      if (!vif.VS) vs_low++;
      if (vif.BLANK) blk++;
      if (!vif.BLANK && vif.RGB != 24'h0) rgb_bad++;
      if (c > 0 && fs) fs_extra++;
    end
    chk("hs_first_low", 64'(first_hs), 64'(4));
    chk("hs_low_cycles", 64'(hs_low), 64'(6 * VT));
    chk("vs_low_cycles", 64'(vs_low), 64'(2 * HT));
    chk("blank_cycles", 64'(blk), 64'(64 * 16));
    chk("rgb_in_blank", 64'(rgb_bad), 64'(0));
    chk("fs_extra", 64'(fs_extra), 64'(0));
    @(negedge clk);
    chk("frame_period", 64'(fs), 64'(1));
    chk("fcnt_one", 64'(fcnt), 64'(1));
    wait_fs("third_frame");
    chk("fcnt_two", 64'(fcnt), 64'(2));

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].grp != vecs[i-1].grp) begin
        mode = vecs[i].mode;
        solid = vecs[i].solid;
        wait_fs("table_group");
        for (int j = i; j < vecs.size() && vecs[j].grp == vecs[i].grp; j++)
          sbq.push_back(vecs[j]);
        drain(-1, 3'd0, 24'h0);
      end
    end

    // mid-frame mode/colour change must wait for the next frame
    mode = 3'd4; solid = 24'h123456;
    wait_fs("solid_frame");
    sb_px(5, 0, 24'h123456);
    sb_px(44, 2, 24'h123456);
    sb_px(44, 10, 24'h123456);
    drain((VS0 + 2) * HT - 40, 3'd3, 24'hABCDEF);
    wait_fs("ramp_frame");
    sb_px(44, 0, 24'h2C2C2C);
    sb_px(44, 3, 24'h2C2C2C);
    drain(-1, 3'd0, 24'h0);

    // enable dropped mid-frame for 100 cycles
    fc0 = fcnt;
    en = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({vif.HS, vif.VS, vif.BLANK, vif.RGB, fs} !== {1'b1, 1'b1, 1'b0, 24'h0, 1'b0}) bad++;
    end
    chk("en_idle", 64'(bad), 64'(0));
    chk("en_fcnt_hold", 64'(fcnt), 64'(fc0));
    en = 1'b1;
    @(negedge clk);
    chk("reen_first", 64'({fs, vif.HS, vif.VS, vif.BLANK}), 64'(4'b1110));
    chk("reen_fcnt", 64'(fcnt), 64'(fc0));
    sb_px(44, 0, 24'h2C2C2C);
    drain(-1, 3'd0, 24'h0);

    // 640-wide, positive sync polarity instance
    bad = 0;
    while (vif2.HS !== 1'b0 && bad < 2000) begin @(negedge clk); bad++; end
    while (vif2.HS !== 1'b1 && bad < 4000) begin @(negedge clk); bad++; end
    hi = 0;
    while (vif2.HS === 1'b1 && hi < 2000) begin @(negedge clk); hi++; end
    per = hi;
    while (vif2.HS !== 1'b1 && per < 2000) begin @(negedge clk); per++; end
    chk("pol1_hs_high", 64'(hi), 64'(48));
    chk("pol1_line_period", 64'(per), 64'(768));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
